i2cio: RTL and testbench

I2CIO -- requirements
Module: i2cio

---
 rtl/i2cio.sv | 192 +++++++++++++++++++
 tb/tb_i2cio.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2cio.sv
// Byte-oriented I2C master with a CPU register window (RX/TX, STATUS/CMD, prescaler).
// One CMD write runs START, one byte (WR or RD) with its ACK, and STOP, each phase being optional.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no transfer; SCL held low after a command without STOP
// S_START | START condition, quarters q0..q3
// S_BIT   | one data bit (8 passes, MSB first), quarters q0..q3
// S_ACK   | ACK bit: sampled after WR, driven from NACK after RD
// S_STOP  | STOP condition, bus released in q3
module i2cio #(
   parameter logic [15:0] PRESC_RST = 16'h001D
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] AD,
   input  logic [7:0] DI,
   output logic [7:0] DO,
   input  logic       rw,
   input  logic       cs,
   output logic       irq,
   input  logic       scl_i,
   output logic       scl_oe,
   input  logic       sda_i,
   output logic       sda_oe
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

   state_t      state, nxt, first_ph;
   logic [1:0]  q;
   logic [2:0]  bit_cnt;
   logic        f_wr, f_rd, f_stop, f_nack;
   logic [7:0]  tx_sh, rx_sh, rxdata, txdata;
   logic [15:0] presc, cnt;
   logic        busy, done, rxnack, ien, hold;
   logic        wr_en, cmd_wr, st_rd, tick;
   logic        drv_scl, drv_sda;
   logic        unused_scl;

   assign unused_scl = scl_i;

   assign wr_en  = cs & ~rw;
   assign cmd_wr = wr_en & (AD == 3'd1);
   assign st_rd  = cs & rw & (AD == 3'd1);
   assign tick   = busy & (cnt == 16'd0);
   assign irq    = done & ien;

   always_comb begin
      DO = 8'hFF;
      case (AD)
         3'd0:    DO = rxdata;
         3'd1:    DO = {ien, 4'b0000, done, rxnack, busy};
         3'd2:    DO = presc[7:0];
         3'd3:    DO = presc[15:8];
         default: DO = 8'hFF;
      endcase
   end

   always_comb begin
      first_ph = S_STOP;
      if (DI[0])
         first_ph = S_START;
      else if (DI[2] | DI[3])
         first_ph = S_BIT;
   end

   always_comb begin
      nxt = S_IDLE;
      case (state)
         S_START: begin
            if (f_wr | f_rd)
               nxt = S_BIT;
            else if (f_stop)
               nxt = S_STOP;
         end
         S_BIT:   nxt = (bit_cnt == 3'd7) ? S_ACK : S_BIT;
         S_ACK:   nxt = f_stop ? S_STOP : S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // Line levels for the current quarter; the pins follow one clk later.
   always_comb begin
      drv_scl = 1'b0;
      drv_sda = 1'b0;
      case (state)
         S_IDLE:  drv_scl = hold;
         S_START: begin
            drv_scl = (q == 2'd3);
            drv_sda = (q >= 2'd2);
         end
         S_BIT: begin
            drv_scl = (q == 2'd0) | (q == 2'd3);
            drv_sda = f_wr & ~tx_sh[7];
         end
         S_ACK: begin
            drv_scl = (q == 2'd0) | (q == 2'd3);
            drv_sda = f_wr ? 1'b0 : ~f_nack;
         end
         S_STOP: begin
            drv_scl = (q == 2'd0);
            drv_sda = (q <= 2'd1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         q       <= 2'd0;
         bit_cnt <= 3'd0;
         f_wr    <= 1'b0;
         f_rd    <= 1'b0;
         f_stop  <= 1'b0;
         f_nack  <= 1'b0;
         tx_sh   <= 8'h00;
         rx_sh   <= 8'h00;
         rxdata  <= 8'h00;
         txdata  <= 8'h00;
         presc   <= PRESC_RST;
         cnt     <= 16'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rxnack  <= 1'b0;
         ien     <= 1'b0;
         hold    <= 1'b0;
         scl_oe  <= 1'b0;
         sda_oe  <= 1'b0;
      end else begin
         scl_oe <= drv_scl;
         sda_oe <= drv_sda;

         if (wr_en) begin
            case (AD)
               3'd0:    txdata      <= DI;
               3'd1:    ien         <= DI[7];
               3'd2:    presc[7:0]  <= DI;
               3'd3:    presc[15:8] <= DI;
               default: ;
            endcase
         end

         if (st_rd)
            done <= 1'b0;

         if (busy)
            cnt <= (cnt == 16'd0) ? presc : cnt - 16'd1;

         if (cmd_wr && !busy && (DI[3:0] != 4'd0)) begin
            busy    <= 1'b1;
            done    <= 1'b0;
            f_wr    <= DI[2];
            f_rd    <= DI[3] & ~DI[2];
            f_stop  <= DI[1];
            f_nack  <= DI[4];
            tx_sh   <= txdata;
            state   <= first_ph;
            q       <= 2'd0;
            bit_cnt <= 3'd0;
            cnt     <= presc;
         end else if (tick) begin
            if (q != 2'd3) begin
               q <= q + 2'd1;
               if (q == 2'd1) begin
                  if (state == S_BIT && !f_wr)
                     rx_sh <= {rx_sh[6:0], sda_i};
                  if (state == S_ACK && f_wr)
                     rxnack <= sda_i;
               end
            end else begin
               q     <= 2'd0;
               state <= nxt;
               if (state == S_BIT) begin
                  tx_sh   <= {tx_sh[6:0], 1'b0};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               // Completion overrides a same-edge STATUS read clearing DONE.
               if (nxt == S_IDLE) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  hold <= (state != S_STOP);
                  if (f_rd)
                     rxdata <= rx_sh;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_i2cio.sv
// Bench for i2cio: register access, WR/RD transfers against an open-drain slave model, reset abort.
module tb_i2cio;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] AD;
   logic [7:0] DI;
   logic [7:0] DO;
   logic       rw, cs, irq;
   logic       scl_i, scl_oe, sda_i, sda_oe;

   int total = 0;
   int bad   = 0;

   // slave model state
   logic       pull = 1'b0;
   logic       rd_mode = 1'b0, wr_mode = 1'b0, ack_en = 1'b0;
   logic [7:0] slave_byte = 8'h00;
   logic [7:0] cap = 8'h00;
   logic       ack_oe = 1'b0;
   logic       scl_prev = 1'b0, sda_prev = 1'b0;
   int         pulses = 0;
   int         starts = 0;
   logic       m_rxnack = 1'b0;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;
   exp_t exp_q[$];

   i2cio dut (
      .clk    (clk),
      .rst    (rst),
      .AD     (AD),
      .DI     (DI),
      .DO     (DO),
      .rw     (rw),
      .cs     (cs),
      .irq    (irq),
      .scl_i  (scl_i),
      .scl_oe (scl_oe),
      .sda_i  (sda_i),
      .sda_oe (sda_oe)
   );

   always #5 clk = ~clk;

   assign scl_i = ~scl_oe;
   assign sda_i = ~(sda_oe | pull);

   always @(negedge clk) begin
      if (scl_prev && !scl_oe) begin
         pulses++;
         if (pulses <= 8)
            cap = {cap[6:0], ~(sda_oe | pull)};
         if (pulses == 9)
            ack_oe = sda_oe;
      end
      if (!scl_prev && scl_oe) begin
         if (pulses < 8)
            pull = rd_mode & ~slave_byte[3'(7 - pulses)];
         else if (pulses == 8)
            pull = wr_mode & ack_en;
         else
            pull = 1'b0;
      end
      if (!sda_prev && sda_oe && !scl_oe && !scl_prev)
         starts++;
      scl_prev = scl_oe;
      sda_prev = sda_oe;
   end

   task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic pop_chk(input logic [15:0] got);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk_val("scoreboard_empty", 16'd1, 16'd0);
      end else begin
         e = exp_q.pop_front();
         chk_val(e.tag, got, e.val);
      end
   endtask

   task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      AD = a; DI = d; cs = 1'b1; rw = 1'b0;
      @(negedge clk);
      cs = 1'b0; rw = 1'b1;
   endtask

   task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
      @(negedge clk);
      AD = a; cs = 1'b1; rw = 1'b1;
      #1 d = DO;
      @(negedge clk);
      cs = 1'b0;
   endtask

   task automatic run_xfer(input logic [7:0] cmd, input logic [7:0] tx, input logic [7:0] sbyte,
                           input logic ack, input logic poke, input int pv);
      int         n;
      int         quarters;
      logic       ien_m;
      logic [7:0] d;

      quarters = (cmd[0] ? 4 : 0) + ((cmd[2] | cmd[3]) ? 36 : 0) + (cmd[1] ? 4 : 0);
      ien_m    = poke ? 1'b0 : cmd[7];
      if (cmd[2])
         m_rxnack = ~ack;

      push_exp("busy_cycles", 16'(quarters * (pv + 1)));
      if (cmd[2])
         push_exp("wr_sda_bits", {8'h00, tx});
      else if (cmd[3]) begin
         push_exp("rd_sda_bits", {8'h00, sbyte});
         push_exp("rxdata", {8'h00, sbyte});
         push_exp("rd_ack_sda_oe", {15'd0, ~cmd[4]});
      end
      push_exp("start_count", {15'd0, cmd[0]});
      push_exp("idle_scl_oe", {15'd0, ~cmd[1]});
      push_exp("irq_done", {15'd0, ien_m});
      push_exp("status", {8'h00, ien_m, 4'b0000, 1'b1, m_rxnack, 1'b0});
      push_exp("irq_after_read", 16'd0);

      pulses = 0; cap = 8'h00; starts = 0; pull = 1'b0; ack_oe = 1'b0;
      rd_mode = cmd[3] & ~cmd[2]; wr_mode = cmd[2]; ack_en = ack; slave_byte = sbyte;

      cpu_write(3'd0, tx);
      cpu_write(3'd1, cmd);
      AD = 3'd1;
      n  = 0;
      while (DO[0] && n < 4000) begin
         if (poke && n == 5) begin
            DI = 8'h01; cs = 1'b1; rw = 1'b0;
         end else begin
            cs = 1'b0; rw = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      cs = 1'b0; rw = 1'b1;
      repeat (3) @(negedge clk);

      pop_chk(16'(n));
      if (cmd[2])
         pop_chk({8'h00, cap});
      else if (cmd[3]) begin
         pop_chk({8'h00, cap});
         cpu_read(3'd0, d);
         pop_chk({8'h00, d});
         pop_chk({15'd0, ack_oe});
      end
      pop_chk(16'(starts));
      pop_chk({15'd0, scl_oe});
      pop_chk({15'd0, irq});
      cpu_read(3'd1, d);
      pop_chk({8'h00, d});
      #1 pop_chk({15'd0, irq});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      cpu_read(3'd2, d);  chk_val("rst_presc_lo", {8'h00, d}, 16'h001D);
      cpu_read(3'd3, d);  chk_val("rst_presc_hi", {8'h00, d}, 16'h0000);
      cpu_read(3'd1, d);  chk_val("rst_status", {8'h00, d}, 16'h0000);
      cpu_read(3'd0, d);  chk_val("rst_rxdata", {8'h00, d}, 16'h0000);
      chk_val("rst_scl_oe", {15'd0, scl_oe}, 16'd0);
      chk_val("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
      chk_val("rst_irq", {15'd0, irq}, 16'd0);
      for (int a = 4; a < 8; a++) begin
         cpu_read(3'(a), d);
         chk_val("unmapped_read", {8'h00, d}, 16'h00FF);
      end

      cpu_write(3'd2, 8'h34);
      cpu_write(3'd3, 8'h12);
      cpu_read(3'd2, d);  chk_val("presc_lo_rw", {8'h00, d}, 16'h0034);
      cpu_read(3'd3, d);  chk_val("presc_hi_rw", {8'h00, d}, 16'h0012);
      cpu_write(3'd2, 8'h00);
      cpu_write(3'd3, 8'h00);

      run_xfer(8'h87, 8'hA5, 8'h00, 1'b1, 1'b0, 0);   // WR, slave ACKs
      run_xfer(8'h87, 8'hA5, 8'h00, 1'b0, 1'b0, 0);   // WR, slave NACKs
      run_xfer(8'h87, 8'h5A, 8'h00, 1'b1, 1'b1, 0);   // CMD poke while busy
      cpu_write(3'd2, 8'h01);
      run_xfer(8'h1A, 8'h00, 8'h3C, 1'b0, 1'b0, 1);   // RD with NACK, slower clock
      cpu_write(3'd2, 8'h00);

      // Abort a WR transfer partway through bit 1 (quarter 10).
      cpu_write(3'd0, 8'hA5);
      cpu_write(3'd1, 8'h87);
      repeat (9) @(negedge clk);
      chk_val("pre_rst_sda_oe", {15'd0, sda_oe}, 16'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_val("abort_scl_oe", {15'd0, scl_oe}, 16'd0);
      chk_val("abort_sda_oe", {15'd0, sda_oe}, 16'd0);
      rst = 1'b0;
      cpu_read(3'd1, d);  chk_val("abort_status", {8'h00, d}, 16'h0000);
      repeat (10) @(negedge clk);
      chk_val("abort_no_stop_sda", {15'd0, sda_oe}, 16'd0);
      chk_val("abort_irq", {15'd0, irq}, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
